// File: rtl/octane_pkg.sv
// Shared constants and FSM state type for the SPI register writer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package octane_pkg;

    localparam int REGISTER_NUMBER_WIDTH = 12;
    localparam int REGISTER_VALUE_WIDTH  = 24;
    localparam int FRAME_BITS            = REGISTER_NUMBER_WIDTH + REGISTER_VALUE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_SHIFT         = 2'd1,
        ST_COMMIT        = 2'd2,
        ST_WAIT_DESELECT = 2'd3
    } state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Two-flop synchronizers for SCLK/CS_n/MOSI plus edge pulses on the synchronized copies.
// Latency: pin change visible on the edge pulses 2-3 i_Clock cycles later.
// Backpressure: none; SPI master is free-running, pulses are single-cycle.
module spi_input_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_n_sync,
    output logic mosi_sync,
    output logic live
);

    logic [1:0] sclk_meta;
    logic [1:0] cs_meta;
    logic [1:0] mosi_meta;
    logic       sclk_prev;
    logic       cs_prev;
    logic [1:0] live_sr;

    // Synchronizer chains reset to idle bus levels, plus one registered copy for edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta <= 2'b00;
            cs_meta   <= 2'b11;
            mosi_meta <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            live_sr   <= 2'b00;
        end else begin
            sclk_meta <= {sclk_meta[0], sclk};
            cs_meta   <= {cs_meta[0], cs_n};
            mosi_meta <= {mosi_meta[0], mosi};
            sclk_prev <= sclk_meta[1];
            cs_prev   <= cs_meta[1];
            live_sr   <= {live_sr[0], 1'b1};
        end
    end

    // Edge pulses; live marks when the chains carry real pin values rather than reset levels.
    always_comb begin
        sclk_rise = sclk_meta[1] & ~sclk_prev;
        cs_fall   = ~cs_meta[1] & cs_prev;
        cs_rise   = cs_meta[1] & ~cs_prev;
        cs_n_sync = cs_meta[1];
        mosi_sync = mosi_meta[1];
        live      = live_sr[1];
    end

endmodule

// File: rtl/spi_register_writer.sv
// SPI-slave frame receiver turning one {register number, value} frame per CS window into a write strobe.
// Latency: write strobe 3 i_Clock cycles after the final SCLK rising edge at the pin.
// Backpressure: none; one write per CS assertion. Optional macro SPI_REGISTER_WRITER_PARITY_EN adds an even-parity bit.
module spi_register_writer #(
    parameter int REGISTER_NUMBER_WIDTH = octane_pkg::REGISTER_NUMBER_WIDTH,
    parameter int REGISTER_VALUE_WIDTH  = octane_pkg::REGISTER_VALUE_WIDTH
) (
    input  logic                             i_Clock,
    input  logic                             i_Reset_n,
    input  logic                             i_SpiClock,
    input  logic                             i_SpiChipSelect_n,
    input  logic                             i_SpiMosi,
    output logic [REGISTER_NUMBER_WIDTH-1:0] o_RegisterNumber,
    output logic [REGISTER_VALUE_WIDTH-1:0]  o_RegisterValue,
    output logic                             o_RegisterWriteEnable,
    output logic                             o_Busy,
    output logic                             o_FrameError
);

    import octane_pkg::*;

    localparam int DATA_BITS = REGISTER_NUMBER_WIDTH + REGISTER_VALUE_WIDTH;
`ifdef SPI_REGISTER_WRITER_PARITY_EN
    localparam int FRAME_LEN = DATA_BITS + 1;
`else
    localparam int FRAME_LEN = DATA_BITS;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 1);

    logic sclk_rise;
    logic cs_fall;
    logic cs_rise;
    logic cs_n_sync;
    logic mosi_sync;
    logic live;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shift_q, shift_d;
    logic [FRAME_LEN-1:0] shift_in;
    logic                 armed_q;
    logic                 commit;
    logic                 load;
    logic                 err_set;
    logic                 par_ok;

    spi_input_sync u_sync (
        .clk       (i_Clock),
        .rst_n     (i_Reset_n),
        .sclk      (i_SpiClock),
        .cs_n      (i_SpiChipSelect_n),
        .mosi      (i_SpiMosi),
        .sclk_rise (sclk_rise),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .cs_n_sync (cs_n_sync),
        .mosi_sync (mosi_sync),
        .live      (live)
    );

    // Frame FSM: the final bit's shift and the output load happen on the same edge, so the
    // strobe and fresh outputs appear together during the COMMIT cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        commit   = 1'b0;
        err_set  = 1'b0;
        shift_in = {shift_q[FRAME_LEN-2:0], mosi_sync};
        case (state_q)
            ST_IDLE: begin
                // A CS that was already low when reset released is not a fresh frame.
                if (cs_fall && armed_q) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    err_set = 1'b1;
                end else if (sclk_rise) begin
                    shift_d = shift_in;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                        state_d = ST_COMMIT;
                        commit  = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                state_d = cs_rise ? ST_IDLE : ST_WAIT_DESELECT;
            end
            ST_WAIT_DESELECT: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef SPI_REGISTER_WRITER_PARITY_EN
        // Even parity: data bits plus parity bit must XOR to zero.
        par_ok = ~(^shift_in);
`else
        par_ok = 1'b1;
`endif
        load = commit & par_ok;
        if (commit && !par_ok) begin
            err_set = 1'b1;
        end
    end

    // FSM, counter and shift-register state.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            armed_q <= armed_q | (live & cs_n_sync);
        end
    end

    // Write-bus outputs: held between commits; strobe lasts exactly the COMMIT cycle.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            o_RegisterNumber      <= '0;
            o_RegisterValue       <= '0;
            o_RegisterWriteEnable <= 1'b0;
            o_FrameError          <= 1'b0;
        end else begin
            o_RegisterWriteEnable <= load;
            if (load) begin
                o_RegisterNumber <= shift_in[FRAME_LEN-1 -: REGISTER_NUMBER_WIDTH];
                o_RegisterValue  <= shift_in[FRAME_LEN-1-REGISTER_NUMBER_WIDTH -: REGISTER_VALUE_WIDTH];
            end
            if (err_set) begin
                o_FrameError <= 1'b1;
            end
        end
    end

    // Busy covers shifting and the commit cycle.
    always_comb begin
        o_Busy = (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
    end

endmodule

// File: tb/tb_spi_register_writer.sv
// Self-checking bench: directed and random SPI frames against a frame-level reference model.
// Latency: strobes captured on any clock; results compared after each CS window.
// Backpressure: n/a.
module tb_spi_register_writer;

    localparam int NW = 12;
    localparam int VW = 24;
    localparam int DB = NW + VW;
`ifdef SPI_REGISTER_WRITER_PARITY_EN
    localparam int FL = DB + 1;
`else
    localparam int FL = DB;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          sclk  = 1'b0;
    logic          cs_n  = 1'b1;
    logic          mosi  = 1'b0;
    logic [NW-1:0] reg_num;
    logic [VW-1:0] reg_val;
    logic          we;
    logic          busy;
    logic          ferr;

    int checks   = 0;
    int failures = 0;

    int            strobes = 0;
    logic [NW-1:0] cap_num = '0;
    logic [VW-1:0] cap_val = '0;

    // Reference model state: what the write bus should show after each frame.
    logic [NW-1:0] exp_num = '0;
    logic [VW-1:0] exp_val = '0;
    logic          exp_err = 1'b0;

    spi_register_writer #(
        .REGISTER_NUMBER_WIDTH (NW),
        .REGISTER_VALUE_WIDTH  (VW)
    ) dut (
        .i_Clock               (clk),
        .i_Reset_n             (rst_n),
        .i_SpiClock            (sclk),
        .i_SpiChipSelect_n     (cs_n),
        .i_SpiMosi             (mosi),
        .o_RegisterNumber      (reg_num),
        .o_RegisterValue       (reg_val),
        .o_RegisterWriteEnable (we),
        .o_Busy                (busy),
        .o_FrameError          (ferr)
    );

    always #5 clk = ~clk;

    // Strobe monitor: every clock with the strobe high counts as one write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            strobes <= strobes + 1;
            cap_num <= reg_num;
            cap_val <= reg_val;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends nbits of the frame {num,val}[,parity][,random extra]; optional reset pulse before bit reset_at.
    task automatic run_frame(input logic [NW-1:0] num, input logic [VW-1:0] val, input int nbits,
                             input bit flip, input int reset_at, input int gap);
        logic          bits [0:63];
        logic [DB-1:0] d;
        int            base;
        bit            wr;
        bit            was_reset;
        d = {num, val};
        for (int i = 0; i < DB; i++) bits[i] = d[DB-1-i];
        for (int i = DB; i < 64; i++) bits[i] = 1'($urandom_range(0, 1));
        if (FL > DB) bits[DB] = (^d) ^ flip;
        base      = strobes;
        was_reset = 1'b0;
        cs_n = 1'b0;
        #100;
        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                rst_n = 1'b0;
                #30;
                check("reset_mid_we", 64'(we), 64'd0);
                check("reset_mid_num", 64'(reg_num), 64'd0);
                check("reset_mid_val", 64'(reg_val), 64'd0);
                check("reset_mid_busy", 64'(busy), 64'd0);
                check("reset_mid_err", 64'(ferr), 64'd0);
                rst_n = 1'b1;
                was_reset = 1'b1;
                #20;
            end
            mosi = bits[i];
            #40 sclk = 1'b1;
            #80 sclk = 1'b0;
            if (i == 10 && !was_reset) check("busy_mid_frame", 64'(busy), 64'd1);
            #40;
        end
        #100 cs_n = 1'b1;
        #(gap);
        wr = 1'b0;
        if (was_reset) begin
            exp_num = '0;
            exp_val = '0;
            exp_err = 1'b0;
        end else if (nbits < FL || flip) begin
            exp_err = 1'b1;
        end else begin
            wr      = 1'b1;
            exp_num = num;
            exp_val = val;
        end
        check("strobe_count", 64'(strobes - base), 64'(wr));
        if (wr) begin
            check("strobe_num", 64'(cap_num), 64'(num));
            check("strobe_val", 64'(cap_val), 64'(val));
        end
        check("held_num", 64'(reg_num), 64'(exp_num));
        check("held_val", 64'(reg_val), 64'(exp_val));
        check("frame_error", 64'(ferr), 64'(exp_err));
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #20;
        check("rst_num", 64'(reg_num), 64'd0);
        check("rst_val", 64'(reg_val), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(ferr), 64'd0);
        rst_n = 1'b1;
        #200;

        // Basic frame.
        run_frame(12'h041, 24'h00ABCD, FL, 1'b0, -1, 300);
        // SCLK activity with CS high is ignored.
        for (int i = 0; i < 5; i++) begin
            #80 sclk = 1'b1;
            #80 sclk = 1'b0;
        end
        #200;
        check("idle_sclk_num", 64'(reg_num), 64'h041);
        // Short frame aborts, then a full frame still writes.
        run_frame(12'h123, 24'h456789, 20, 1'b0, -1, 300);
        run_frame(12'h045, 24'h000001, FL, 1'b0, -1, 300);
        // Over-long frame: extra bits ignored.
        run_frame(12'h042, 24'h123456, FL + 4, 1'b0, -1, 300);
        // Reset at bit 18 discards the frame; next frame writes normally.
        run_frame(12'h7FF, 24'hFFFFFF, FL, 1'b0, 18, 300);
        run_frame(12'h006, 24'h0003FF, FL, 1'b0, -1, 300);
        // Back-to-back frames, one SCLK period of CS high between them.
        run_frame(12'h041, 24'h000010, FL, 1'b0, -1, 160);
        run_frame(12'h081, 24'h000020, FL, 1'b0, -1, 300);
`ifdef SPI_REGISTER_WRITER_PARITY_EN
        run_frame(12'h002, 24'h100000, FL, 1'b1, -1, 300);
        run_frame(12'h002, 24'h100000, FL, 1'b0, -1, 300);
`endif
        // Random frames: full, long and short lengths.
        for (int k = 0; k < 8; k++) begin
            int  sel;
            int  n;
            bit  fl;
            sel = int'($urandom_range(0, 2));
            if (sel == 0) n = FL;
            else if (sel == 1) n = FL + int'($urandom_range(1, 5));
            else n = int'($urandom_range(1, FL - 1));
            fl = 1'b0;
`ifdef SPI_REGISTER_WRITER_PARITY_EN
            fl = 1'($urandom_range(0, 1));
`endif
            run_frame(NW'($urandom), VW'($urandom), n, fl, -1, 300);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
